ftdi_cmd_sequencer: RTL and testbench
=====================================

FTDI_CMD_SEQUENCER -- requirements
Module: ftdi_cmd_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50000, inter-byte RX timeout in in_clk cycles.
REQ-002 SHALL have parameter RD_LAT, default 2, cycles from out_reg_rd to valid in_reg_rdata.
REQ-003 SHALL have parameter ACK_BYTE, default 8'hA5, write-completion reply byte.
REQ-004 in_clk  input  1  clock; all logic on rising edge.
REQ-005 in_rst  input  1  reset, asynchronous, active-high.
REQ-006 out_rx_en  output  1  enables FTDI RX in controller.
REQ-007 in_rx_data  input  8  byte from controller.
REQ-008 in_rx_hsk_req  input  1  controller RX byte request.
REQ-009 out_rx_hsk_ack  output  1  RX acknowledge.
REQ-010 out_tx_data  output  8  byte to controller.
REQ-011 out_tx_hsk_req  output  1  TX request.
REQ-012 in_tx_hsk_ack  input  1  controller TX acknowledge.
REQ-013 in_ftdi_wr  input  1  controller FTDI write strobe, monitored for byte completion.
REQ-014 out_reg_addr  output  7  register address.
REQ-015 out_reg_wdata  output  8  register write data.
REQ-016 out_reg_wr / out_reg_rd  output  1  one-cycle strobes.
REQ-017 in_reg_rdata  input  8  register read data.
REQ-018 out_err_cnt  output  8  saturating timeout-error count.

Function
REQ-019 Packet: byte0 = {W, addr[6:0]}; byte1 = count N, 0 meaning 256; W=1 then N data bytes follow.
REQ-020 States: IDLE, GET_LEN, GET_DATA, REG_WR, REG_RD, RD_WAIT, TX_REQ, TX_ACKW, TX_DONEW.
REQ-021 RX byte, four-phase: in_rx_hsk_req high in IDLE/GET_LEN/GET_DATA -> latch in_rx_data, raise out_rx_hsk_ack; hold until req low; then drop ack and advance.
REQ-022 out_rx_en SHALL be high only in IDLE, GET_LEN, GET_DATA.
REQ-023 Write: each data byte -> REG_WR, one-cycle out_reg_wr with current addr/data; addr += 1, mod 128 wrap (7'h7F -> 7'h00).
REQ-024 After the N-th write SHALL transmit ACK_BYTE exactly once.
REQ-025 Read: after count, per byte: one-cycle out_reg_rd; sample in_reg_rdata RD_LAT cycles later into out_tx_data; transmit; addr += 1 with wrap; repeat N times.
REQ-026 TX byte: out_tx_data stable, raise out_tx_hsk_req (TX_REQ); in_tx_hsk_ack high -> drop req (TX_ACKW); wait for in_tx_hsk_ack low, then in_ftdi_wr falling edge (TX_DONEW); only then may out_tx_data change.
REQ-027 out_tx_data SHALL hold its value from request rise until the in_ftdi_wr falling edge.
REQ-028 Remaining-count counter 9 bits; N=0 loads 256.
REQ-029 Timeout counter clears on each accepted RX byte; in GET_LEN/GET_DATA reaching TIMEOUT_CYCLES -> IDLE, packet discarded, out_err_cnt += 1, saturating at 255.
REQ-030 Timeout SHALL NOT apply in IDLE or TX/read states.
REQ-031 Writes already issued before a timeout SHALL NOT be undone; no ACK_BYTE sent.

Reset
REQ-032 Asynchronous reset SHALL force IDLE, all strobes/acks/req low, out_tx_data 0, out_reg_addr 0, out_reg_wdata 0, out_err_cnt 0, counters 0.
REQ-033 Reset mid-packet SHALL abandon the packet; out_rx_en high after release.

Structure
REQ-034 Package ftdi_seq_pkg SHALL hold the state encoding, ACK_BYTE default, W bit position.
REQ-035 TX handshake plus in_ftdi_wr edge detect SHALL be sub-module ftdi_seq_tx (start, data in; done out).

Verification
REQ-036 RX 8'h85, 8'h02, 8'h11, 8'h22 -> writes addr5=11, addr6=22; TX 8'hA5 once.
REQ-037 RX 8'h7F, 8'h02, regs 7F=AA, 00=BB -> reads 7F then 00; TX AA, BB.
REQ-038 RX 8'h00, 8'h00 -> 256 reads, addr 0..7F twice; 256 TX bytes.
REQ-039 RX 8'h81, then silence TIMEOUT_CYCLES -> IDLE, no write, out_err_cnt=1; 256 timeouts -> 255.
REQ-040 Delay in_ftdi_wr fall 20 cycles -> out_tx_data stable, no new out_tx_hsk_req until fall.
REQ-041 Assert in_rst during read burst -> all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/ftdi_seq_pkg.sv
// Shared encodings for the FTDI command sequencer and its TX handshake engine.
package ftdi_seq_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StGetLen,
        StGetData,
        StRegWr,
        StRegRd,
        StRdWait,
        StTxReq,
        StTxAckw,
        StTxDonew
    } seq_state_e;

    localparam logic [7:0]  ACK_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned W_BIT            = 7;

endpackage

// File: rtl/ftdi_seq_tx.sv
// Single-byte TX handshake toward the FTDI controller; holds the byte until the
// controller's write strobe falls, then pulses out_done.
module ftdi_seq_tx
    import ftdi_seq_pkg::*;
(
    input  logic       in_clk,
    input  logic       in_rst,
    input  logic       in_start,
    input  logic [7:0] in_data,
    input  logic       in_tx_hsk_ack,
    input  logic       in_ftdi_wr,
    output logic [7:0] out_tx_data,
    output logic       out_tx_hsk_req,
    output logic       out_done
);

    seq_state_e phase;
    logic       ftdi_wr_q;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            phase          <= StIdle;
            out_tx_data    <= 8'h00;
            out_tx_hsk_req <= 1'b0;
            out_done       <= 1'b0;
            ftdi_wr_q      <= 1'b0;
        end else begin
            ftdi_wr_q <= in_ftdi_wr;
            out_done  <= 1'b0;
            case (phase)
                StTxReq: begin
                    if (in_tx_hsk_ack) begin
                        out_tx_hsk_req <= 1'b0;
                        phase          <= StTxAckw;
                    end
                end
                StTxAckw: begin
                    if (!in_tx_hsk_ack) begin
                        phase <= StTxDonew;
                    end
                end
                StTxDonew: begin
                    // out_tx_data must not move until the controller has consumed it
                    if (ftdi_wr_q && !in_ftdi_wr) begin
                        out_done <= 1'b1;
                        phase    <= StIdle;
                    end
                end
                default: begin
                    if (in_start) begin
                        out_tx_data    <= in_data;
                        out_tx_hsk_req <= 1'b1;
                        phase          <= StTxReq;
                    end else begin
                        phase <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/ftdi_cmd_sequencer.sv
// Packet-driven register access over the FTDI byte handshake: {W,addr} + count headers,
// then N register writes (acked once) or N register reads streamed back. RD_LAT >= 1.
module ftdi_cmd_sequencer
    import ftdi_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned RD_LAT         = 2,
    parameter logic [7:0]  ACK_BYTE       = ACK_BYTE_DEFAULT
) (
    input  logic       in_clk,
    input  logic       in_rst,
    output logic       out_rx_en,
    input  logic [7:0] in_rx_data,
    input  logic       in_rx_hsk_req,
    output logic       out_rx_hsk_ack,
    output logic [7:0] out_tx_data,
    output logic       out_tx_hsk_req,
    input  logic       in_tx_hsk_ack,
    input  logic       in_ftdi_wr,
    output logic [6:0] out_reg_addr,
    output logic [7:0] out_reg_wdata,
    output logic       out_reg_wr,
    output logic       out_reg_rd,
    input  logic [7:0] in_reg_rdata,
    output logic [7:0] out_err_cnt
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LAT_W = $clog2(RD_LAT + 1);

    seq_state_e       state;
    logic [7:0]       rx_byte;
    logic             is_wr;
    logic [8:0]       rem_cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [LAT_W-1:0] lat_cnt;
    logic             tx_start;
    logic [7:0]       tx_byte;
    logic             tx_done;
    logic             rx_phase;

    assign rx_phase  = (state == StIdle) || (state == StGetLen) || (state == StGetData);
    assign out_rx_en = rx_phase;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state          <= StIdle;
            rx_byte        <= 8'h00;
            is_wr          <= 1'b0;
            rem_cnt        <= 9'd0;
            tmo_cnt        <= '0;
            lat_cnt        <= '0;
            tx_start       <= 1'b0;
            tx_byte        <= 8'h00;
            out_rx_hsk_ack <= 1'b0;
            out_reg_addr   <= 7'h00;
            out_reg_wdata  <= 8'h00;
            out_reg_wr     <= 1'b0;
            out_reg_rd     <= 1'b0;
            out_err_cnt    <= 8'h00;
        end else begin
            out_reg_wr <= 1'b0;
            out_reg_rd <= 1'b0;
            tx_start   <= 1'b0;
            if (rx_phase) begin
                if (in_rx_hsk_req && !out_rx_hsk_ack) begin
                    rx_byte        <= in_rx_data;
                    out_rx_hsk_ack <= 1'b1;
                    tmo_cnt        <= '0;
                end else if (!in_rx_hsk_req && out_rx_hsk_ack) begin
                    // byte is only acted on once the four-phase handshake has closed
                    out_rx_hsk_ack <= 1'b0;
                    tmo_cnt        <= '0;
                    case (state)
                        StGetLen: begin
                            rem_cnt <= (rx_byte == 8'h00) ? 9'd256 : {1'b0, rx_byte};
                            if (is_wr) begin
                                state <= StGetData;
                            end else begin
                                out_reg_rd <= 1'b1;
                                state      <= StRegRd;
                            end
                        end
                        StGetData: begin
                            out_reg_wdata <= rx_byte;
                            out_reg_wr    <= 1'b1;
                            state         <= StRegWr;
                        end
                        default: begin
                            out_reg_addr <= rx_byte[6:0];
                            is_wr        <= rx_byte[W_BIT];
                            state        <= StGetLen;
                        end
                    endcase
                end else if (state != StIdle) begin
                    if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state          <= StIdle;
                        out_rx_hsk_ack <= 1'b0;
                        tmo_cnt        <= '0;
                        if (out_err_cnt != 8'hFF) begin
                            out_err_cnt <= out_err_cnt + 8'd1;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
            end else begin
                tmo_cnt <= '0;
                case (state)
                    StRegWr: begin
                        out_reg_addr <= out_reg_addr + 7'd1;
                        rem_cnt      <= rem_cnt - 9'd1;
                        if (rem_cnt == 9'd1) begin
                            tx_byte  <= ACK_BYTE;
                            tx_start <= 1'b1;
                            state    <= StTxReq;
                        end else begin
                            state <= StGetData;
                        end
                    end
                    StRegRd: begin
                        out_reg_addr <= out_reg_addr + 7'd1;
                        lat_cnt      <= LAT_W'(1);
                        state        <= StRdWait;
                    end
                    StRdWait: begin
                        if (lat_cnt == LAT_W'(RD_LAT)) begin
                            tx_byte  <= in_reg_rdata;
                            tx_start <= 1'b1;
                            rem_cnt  <= rem_cnt - 9'd1;
                            state    <= StTxReq;
                        end else begin
                            lat_cnt <= lat_cnt + 1'b1;
                        end
                    end
                    StTxReq: begin
                        if (tx_done) begin
                            if (is_wr || (rem_cnt == 9'd0)) begin
                                state <= StIdle;
                            end else begin
                                out_reg_rd <= 1'b1;
                                state      <= StRegRd;
                            end
                        end
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

    ftdi_seq_tx u_tx (
        .in_clk         (in_clk),
        .in_rst         (in_rst),
        .in_start       (tx_start),
        .in_data        (tx_byte),
        .in_tx_hsk_ack  (in_tx_hsk_ack),
        .in_ftdi_wr     (in_ftdi_wr),
        .out_tx_data    (out_tx_data),
        .out_tx_hsk_req (out_tx_hsk_req),
        .out_done       (tx_done)
    );

endmodule

// File: tb/tb_ftdi_cmd_sequencer.sv
// Scoreboard bench for ftdi_cmd_sequencer: random packets against a memory-array reference
// model, plus directed timeout, TX-hold and mid-burst reset scenarios.
module tb_ftdi_cmd_sequencer;

    localparam int unsigned TMO    = 100;
    localparam int unsigned RD_LAT = 3;
    localparam logic [7:0]  ACK    = 8'hA5;

    logic       clk;
    logic       rst;
    logic       rx_en;
    logic [7:0] rx_data;
    logic       rx_req;
    logic       rx_ack;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       tx_ack;
    logic       ftdi_wr;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic [7:0] err_cnt;

    ftdi_cmd_sequencer #(
        .TIMEOUT_CYCLES (TMO),
        .RD_LAT         (RD_LAT)
    ) dut (
        .in_clk         (clk),
        .in_rst         (rst),
        .out_rx_en      (rx_en),
        .in_rx_data     (rx_data),
        .in_rx_hsk_req  (rx_req),
        .out_rx_hsk_ack (rx_ack),
        .out_tx_data    (tx_data),
        .out_tx_hsk_req (tx_req),
        .in_tx_hsk_ack  (tx_ack),
        .in_ftdi_wr     (ftdi_wr),
        .out_reg_addr   (reg_addr),
        .out_reg_wdata  (reg_wdata),
        .out_reg_wr     (reg_wr),
        .out_reg_rd     (reg_rd),
        .in_reg_rdata   (reg_rdata),
        .out_err_cnt    (err_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [14:0] exp_wr_q[$];
    logic [6:0]  exp_rd_q[$];
    logic [7:0]  exp_tx_q[$];
    logic [7:0]  pkt_data[$];
    logic [7:0]  ref_mem[128];
    logic [7:0]  regfile[128];
    logic [8:0]  pipe[RD_LAT+1];

    int ph       = 0;
    int tx_count = 0;
    int wr_hold  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name, input logic [63:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h expected none", name, act);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor for register strobes.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (reg_wr) begin
                    if (exp_wr_q.size() == 0) flag_fail("unexpected_reg_wr", {reg_addr, reg_wdata});
                    else check("reg_wr", {reg_addr, reg_wdata}, exp_wr_q.pop_front());
                end
                if (reg_rd) begin
                    if (exp_rd_q.size() == 0) flag_fail("unexpected_reg_rd", reg_addr);
                    else check("reg_rd_addr", reg_addr, exp_rd_q.pop_front());
                end
            end
        end
    end

    // Register file with RD_LAT read latency; off-cycle data is poisoned.
    initial begin
        reg_rdata = 8'hEE;
        for (int k = 0; k <= RD_LAT; k++) pipe[k] = 9'h0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                for (int k = 0; k <= RD_LAT; k++) pipe[k] = 9'h0;
                reg_rdata = 8'hEE;
            end else begin
                for (int k = RD_LAT; k > 0; k--) pipe[k] = pipe[k-1];
                pipe[0]   = {reg_rd, regfile[reg_addr]};
                reg_rdata = pipe[RD_LAT][8] ? pipe[RD_LAT][7:0] : 8'hEE;
                if (reg_wr) regfile[reg_addr] = reg_wdata;
            end
        end
    end

    // Controller-side TX responder and TX monitor.
    initial begin
        int         dly;
        int         wt;
        logic [7:0] cap;
        bit         bad;
        tx_ack  = 1'b0;
        ftdi_wr = 1'b0;
        dly     = 0;
        wt      = 0;
        cap     = 8'h00;
        bad     = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                ph      = 0;
                tx_ack  = 1'b0;
                ftdi_wr = 1'b0;
            end else begin
                case (ph)
                    0: if (tx_req) begin
                        cap = tx_data;
                        bad = 1'b0;
                        if (exp_tx_q.size() == 0) flag_fail("unexpected_tx", cap);
                        else check("tx_byte", cap, exp_tx_q.pop_front());
                        dly = $urandom_range(0, 3);
                        ph  = 1;
                    end
                    1: begin
                        if (tx_data != cap || !tx_req) bad = 1'b1;
                        if (dly == 0) begin
                            tx_ack  = 1'b1;
                            ftdi_wr = 1'b1;
                            wt      = 0;
                            ph      = 2;
                        end else dly--;
                    end
                    2: begin
                        if (tx_data != cap) bad = 1'b1;
                        wt++;
                        if (!tx_req || wt > 100) begin
                            if (tx_req) flag_fail("tx_req_drop", 1);
                            tx_ack = 1'b0;
                            dly    = (wr_hold > 0) ? wr_hold : $urandom_range(3, 6);
                            ph     = 3;
                        end
                    end
                    default: begin
                        if (tx_data != cap || tx_req) bad = 1'b1;
                        if (dly == 0) begin
                            ftdi_wr = 1'b0;
                            check("tx_hold_until_wr_fall", bad, 0);
                            tx_count++;
                            ph = 0;
                        end else dly--;
                    end
                endcase
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        while (!rx_en && t < 20000) begin cyc(1); t++; end
        if (!rx_en) flag_fail("rx_en_wait", 0);
        rx_data = b;
        rx_req  = 1'b1;
        t = 0;
        while (!rx_ack && t < 50) begin cyc(1); t++; end
        if (!rx_ack) flag_fail("rx_ack_rise", 0);
        rx_req = 1'b0;
        t = 0;
        while (rx_ack && t < 50) begin cyc(1); t++; end
        if (rx_ack) flag_fail("rx_ack_fall", 1);
    endtask

    task automatic rx_gap();
        cyc($urandom_range(0, 4));
    endtask

    task automatic run_packet(input bit w, input logic [6:0] a, input int n);
        logic [6:0] ad;
        logic [7:0] d;
        ad = a;
        if (!w) begin
            for (int i = 0; i < n; i++) begin
                exp_rd_q.push_back(ad);
                exp_tx_q.push_back(ref_mem[ad]);
                ad = ad + 7'd1;
            end
        end
        send_byte({w, a});
        rx_gap();
        send_byte((n == 256) ? 8'h00 : n[7:0]);
        if (w) begin
            for (int i = 0; i < n; i++) begin
                if (pkt_data.size() != 0) d = pkt_data.pop_front();
                else d = 8'($urandom);
                exp_wr_q.push_back({ad, d});
                ref_mem[ad] = d;
                ad = ad + 7'd1;
                rx_gap();
                send_byte(d);
            end
            exp_tx_q.push_back(ACK);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_tx_q.size() != 0 || exp_rd_q.size() != 0 || exp_wr_q.size() != 0 ||
                ph != 0 || !rx_en) && t < 20000) begin
            cyc(1);
            t++;
        end
        if (t >= 20000) flag_fail("drain_timeout", exp_tx_q.size());
        cyc(5);
    endtask

    initial begin
        int         c0;
        logic [7:0] v;
        rst     = 1'b1;
        rx_req  = 1'b0;
        rx_data = 8'h00;
        for (int i = 0; i < 128; i++) begin
            v          = 8'($urandom);
            regfile[i] = v;
            ref_mem[i] = v;
        end
        cyc(3);
        check("reset_outputs", {rx_ack, tx_req, tx_data, reg_addr, reg_wdata, reg_wr, reg_rd,
                                err_cnt}, 64'h0);
        check("reset_rx_en", rx_en, 1);
        rst = 1'b0;
        cyc(2);

        // Two writes from address 5, single ack.
        pkt_data.push_back(8'h11);
        pkt_data.push_back(8'h22);
        run_packet(1'b1, 7'h05, 2);
        drain();

        // Read wrapping 7F -> 00.
        regfile[7'h7F] = 8'hAA;
        ref_mem[7'h7F] = 8'hAA;
        regfile[7'h00] = 8'hBB;
        ref_mem[7'h00] = 8'hBB;
        run_packet(1'b0, 7'h7F, 2);
        drain();

        // Controller holds in_ftdi_wr high for 20 cycles after ack.
        wr_hold = 20;
        run_packet(1'b0, 7'($urandom), 2);
        drain();
        wr_hold = 0;

        // Count 0 means 256 reads.
        c0 = tx_count;
        run_packet(1'b0, 7'h00, 256);
        drain();
        check("read256_tx_count", tx_count - c0, 256);
        check("no_timeout_in_read", err_cnt, 0);

        for (int p = 0; p < 25; p++) begin
            run_packet(1'($urandom), 7'($urandom), $urandom_range(1, 6));
            rx_gap();
        end
        drain();

        // Header then silence.
        send_byte(8'h81);
        cyc(TMO + 20);
        check("timeout_err_1", err_cnt, 1);
        check("timeout_back_idle", rx_en, 1);

        // Partial write: the issued write stays, no ack byte.
        send_byte(8'h90);
        send_byte(8'h03);
        exp_wr_q.push_back({7'h10, 8'h3C});
        ref_mem[7'h10] = 8'h3C;
        send_byte(8'h3C);
        cyc(TMO + 20);
        check("timeout_err_2", err_cnt, 2);
        check("partial_write_issued", exp_wr_q.size(), 0);
        cyc(3 * TMO);
        check("no_timeout_in_idle", err_cnt, 2);

        for (int i = 0; i < 254; i++) begin
            send_byte(8'($urandom));
            cyc(TMO + 10);
        end
        check("timeout_saturate", err_cnt, 255);

        // Asynchronous reset in the middle of a read burst.
        c0 = tx_count;
        run_packet(1'b0, 7'h40, 200);
        begin
            int t;
            t = 0;
            while (tx_count - c0 < 10 && t < 5000) begin cyc(1); t++; end
            if (t >= 5000) flag_fail("burst_progress", tx_count - c0);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("reset_mid_read", {rx_ack, tx_req, tx_data, reg_addr, reg_wdata, reg_wr, reg_rd,
                                 err_cnt}, 64'h0);
        exp_wr_q.delete();
        exp_rd_q.delete();
        exp_tx_q.delete();
        cyc(3);
        rst = 1'b0;
        cyc(1);
        check("rx_en_after_reset", rx_en, 1);

        run_packet(1'b1, 7'h7E, 3);
        run_packet(1'b0, 7'h7E, 3);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
